// File: rtl/bnn_argmax_engine.sv
// Binary neural-network output layer: XNOR-popcount of the input vector
// against N_OUT stored weight rows, WORD bits per cycle, argmax selection.
// Ports: clk, rst (async active-low), start/in_vec request a classification,
// w_we/w_addr/w_data write weight rows while idle, busy/done/result/score
// report progress and the winning class with its popcount.
module bnn_argmax_engine #(
    parameter int N_IN  = 64,
    parameter int N_OUT = 10,
    parameter int WORD  = 16,
    localparam int CH      = N_IN / WORD,
    localparam int CLS_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int SCORE_W = $clog2(N_IN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_IN-1:0]    in_vec,
    input  logic               w_we,
    input  logic [CLS_W-1:0]   w_addr,
    input  logic [N_IN-1:0]    w_data,
    output logic               busy,
    output logic               done,
    output logic [CLS_W-1:0]   result,
    output logic [SCORE_W-1:0] score
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [N_IN-1:0]    w_mem [N_OUT];
    logic [N_IN-1:0]    x_reg;
    logic [CLS_W-1:0]   cls;
    logic [CH_W-1:0]    chunk;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] best;
    logic [CLS_W-1:0]   best_idx;
    logic               fin;

    logic [N_IN-1:0]    w_row;
    logic [WORD-1:0]    agree;
    logic [SCORE_W-1:0] pop;
    logic [SCORE_W-1:0] sum;
    logic               last_chunk;
    logic               last_cls;
    logic               addr_ok;

    assign busy = (state != IDLE);
    assign addr_ok = ({1'b0, w_addr} < (CLS_W + 1)'(N_OUT));
    assign last_chunk = (chunk == CH_W'(CH - 1));
    assign last_cls = (cls == CLS_W'(N_OUT - 1));

    // Weight rows survive reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (w_we && !busy && addr_ok) begin
            w_mem[w_addr] <= w_data;
        end
    end

    always_comb begin
        w_row = w_mem[cls];
        agree = ~(x_reg[int'(chunk)*WORD +: WORD] ^ w_row[int'(chunk)*WORD +: WORD]);
        pop = '0;
        for (int i = 0; i < WORD; i++) begin
            pop = pop + SCORE_W'(agree[i]);
        end
        sum = acc + pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // fin marks that the last chunk of the last class has been folded into
    // best; the following RUN cycle publishes the result.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fin) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg    <= '0;
            cls      <= '0;
            chunk    <= '0;
            acc      <= '0;
            best     <= '0;
            best_idx <= '0;
            fin      <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            score    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_reg    <= in_vec;
                        cls      <= '0;
                        chunk    <= '0;
                        acc      <= '0;
                        best     <= '0;
                        best_idx <= '0;
                        fin      <= 1'b0;
                    end
                end
                RUN: begin
                    if (fin) begin
                        result <= best_idx;
                        score  <= best;
                        done   <= 1'b1;
                        fin    <= 1'b0;
                    end else if (last_chunk) begin
                        chunk <= '0;
                        acc   <= '0;
                        // Strict compare keeps the lower index on ties.
                        if (cls == '0 || sum > best) begin
                            best     <= sum;
                            best_idx <= cls;
                        end
                        if (last_cls) begin
                            fin <= 1'b1;
                        end else begin
                            cls <= cls + CLS_W'(1);
                        end
                    end else begin
                        chunk <= chunk + CH_W'(1);
                        acc   <= sum;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
